instr_fetch_queue: RTL and testbench
====================================

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DEPTH, 4, queue entries (power of two, >=2).
- RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_i, in, 1, single clock; all state updates on rising edge.
- rst_i, in, 1, reset; asynchronous, active-high.
- imem_req_o, out, 1, fetch request to instruction memory.
- imem_addr_o, out, 32, fetch address; held stable while imem_req_o=1.
- imem_ack_i, in, 1, memory completes request; imem_data_i valid this cycle.
- imem_data_i, in, 32, fetched instruction word.
- redirect_i, in, 1, taken branch/jump; flush and refetch.
- redirect_pc_i, in, 32, new fetch address, sampled when redirect_i=1.
- instr_valid_o, out, 1, queue head valid.
- instr_o, out, 32, head instruction.
- pc_o, out, 32, head instruction address.
- instr_ready_i, in, 1, decoder accepts head.
- count_o, out, log2(DEPTH)+1, occupied entries.

Function
REQ-003 Block SHALL hold a circular FIFO of DEPTH {pc,instr} entries with read/write pointers and a count register.
REQ-004 instr_valid_o SHALL equal (count!=0); instr_o/pc_o SHALL present the head entry combinationally from registers.
REQ-005 Pop SHALL occur when instr_valid_o && instr_ready_i && !redirect_i.
REQ-006 FSM states SHALL be IDLE, WAIT, DROP; imem_req_o=1 exactly in WAIT and DROP.
REQ-007 imem_addr_o SHALL come from a req_addr register, loaded only on entry to WAIT, never changed during WAIT/DROP.
REQ-008 Register fetch_pc SHALL hold next address to request; incremented by 4 (mod 2^32, wraps silently) on every accepted push.
REQ-009 IDLE: redirect_i -> fetch_pc<=redirect_pc_i, stay IDLE; else count<DEPTH -> WAIT, req_addr<=fetch_pc; else stay IDLE.
REQ-010 WAIT, no ack, no redirect: stay WAIT.
REQ-011 WAIT, ack, no redirect: push {req_addr, imem_data_i}, fetch_pc<=req_addr+4; if (count+1-pop)<DEPTH stay WAIT with req_addr<=req_addr+4 (back-to-back), else IDLE.
REQ-012 WAIT, redirect, no ack: flush, fetch_pc<=redirect_pc_i, go DROP.
REQ-013 WAIT, redirect and ack same cycle: data discarded (no push), flush, fetch_pc<=redirect_pc_i, go IDLE.
REQ-014 DROP: ack -> data discarded, go IDLE; redirect in DROP -> fetch_pc<=redirect_pc_i (latest wins), flush, stay DROP unless ack.
REQ-015 Flush SHALL zero count and both pointers next edge; redirect SHALL take priority over push and pop in the same cycle.
REQ-016 Outputs during the redirect cycle itself reflect pre-flush state; decoder SHALL ignore them.
REQ-017 Push into a full queue SHALL be impossible by construction (at most one outstanding request, issued only when count<DEPTH).
REQ-018 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-019 Latency: ack at edge N -> entry visible on instr_o/pc_o after edge N (one cycle); sustained rate one instruction per cycle when ack is held high and ready=1.

Reset
REQ-020 rst_i=1 SHALL immediately (asynchronously) force: state IDLE, fetch_pc=RESET_PC, req_addr=RESET_PC, count=0, pointers 0, all entries 0.
REQ-021 Reset values: imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, pc_o=0, count_o=0; in-flight request is abandoned.

Verification
REQ-022 Reset release, ack=1 every cycle, ready=1 -> req high from 2nd edge, addrs 0,4,8,12,...; pc_o/instr_o in order, one per cycle.
REQ-023 ready=0, ack=1 -> exactly 4 requests (0..12), count_o=4, req drops; ready=1 one cycle -> count_o=3, next request addr 16.
REQ-024 redirect_i=1, redirect_pc_i=0x100 while WAIT, ack two cycles later with 0xDEAD -> DROP, 0xDEAD discarded, next request addr 0x100, count_o=0.
REQ-025 redirect (0x200) same cycle as ack -> no push, count_o=0 next cycle, next request addr 0x200.
REQ-026 rst_i pulsed mid-WAIT with 3 entries queued -> outputs reset immediately without clock edge; after release first request addr RESET_PC.
REQ-027 fetch_pc=0xFFFF_FFFC, ack -> following request addr 0x0000_0000.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction fetch unit: issues one outstanding memory request at a time and
// buffers returned {pc, instr} pairs in a small circular queue for the decoder.
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    output logic                     imem_req_o,
    output logic [31:0]              imem_addr_o,
    input  logic                     imem_ack_i,
    input  logic [31:0]              imem_data_i,
    input  logic                     redirect_i,
    input  logic [31:0]              redirect_pc_i,
    output logic                     instr_valid_o,
    output logic [31:0]              instr_o,
    output logic [31:0]              pc_o,
    input  logic                     instr_ready_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t         state, state_nxt;
    logic [31:0]    fetch_pc, fetch_pc_nxt;
    logic [31:0]    req_addr, req_addr_nxt;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic [31:0]    pc_mem    [DEPTH];
    logic [31:0]    instr_mem [DEPTH];
    logic           push, pop, flush;

    // A redirect kills any pop in the same cycle; the decoder ignores outputs then.
    assign pop   = (count != '0) && instr_ready_i && !redirect_i;
    assign flush = redirect_i;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        req_addr_nxt = req_addr;
        push         = 1'b0;
        case (state)
            IDLE: begin
                if (redirect_i) begin
                    fetch_pc_nxt = redirect_pc_i;
                end else if (count < CW'(DEPTH)) begin
                    state_nxt    = WAIT;
                    req_addr_nxt = fetch_pc;
                end
            end
            WAIT: begin
                if (redirect_i) begin
                    fetch_pc_nxt = redirect_pc_i;
                    state_nxt    = imem_ack_i ? IDLE : DROP;
                end else if (imem_ack_i) begin
                    push         = 1'b1;
                    fetch_pc_nxt = req_addr + 32'd4;
                    // Keep streaming only if the queue still has room after this push/pop.
                    if (pop || count < CW'(DEPTH - 1)) begin
                        req_addr_nxt = req_addr + 32'd4;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DROP: begin
                if (redirect_i) fetch_pc_nxt = redirect_pc_i;
                if (imem_ack_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            req_addr <= req_addr_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            // NOTE: the storage is reset too, so the head outputs read zero out of reset.
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]    <= req_addr;
                instr_mem[wr_ptr] <= imem_data_i;
                wr_ptr            <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign imem_req_o    = (state != IDLE);
    assign imem_addr_o   = req_addr;
    assign instr_valid_o = (count != '0);
    assign instr_o       = instr_mem[rd_ptr];
    assign pc_o          = pc_mem[rd_ptr];
    assign count_o       = count;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed scenarios plus random
// ack/ready/redirect traffic checked against a queue-based reference model.
module tb_instr_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned CW       = $clog2(DEPTH) + 1;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          imem_req_o;
    logic [31:0]   imem_addr_o;
    logic          imem_ack_i;
    logic [31:0]   imem_data_i;
    logic          redirect_i;
    logic [31:0]   redirect_pc_i;
    logic          instr_valid_o;
    logic [31:0]   instr_o;
    logic [31:0]   pc_o;
    logic          instr_ready_i;
    logic [CW-1:0] count_o;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_data_i   (imem_data_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .instr_ready_i (instr_ready_i),
        .count_o       (count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    // Reference model: queue contents, next fresh fetch address, and the
    // address of an abandoned request still waiting for its ack.
    entry_t      q[$];
    logic [31:0] exp_addr;
    logic [31:0] stale_addr;
    bit          stale;
    int          pushes;
    int          checks;
    int          passed;

    task automatic model_clear();
        q.delete();
        exp_addr   = RESET_PC;
        stale      = 1'b0;
        stale_addr = RESET_PC;
    endtask

    task automatic do_reset();
        imem_ack_i = 1'b0; imem_data_i = '0; redirect_i = 1'b0;
        redirect_pc_i = '0; instr_ready_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        model_clear();
    endtask

    // Called at a falling edge: compare outputs with the model, apply inputs for
    // the next rising edge, advance the model, then wait for the next falling edge.
    task automatic step(input bit ack, input logic [31:0] data, input bit rdy,
                        input bit redir, input logic [31:0] rpc);
        bit     ack_eff;
        bit     do_pop;
        entry_t head;
        checks++;
        if (count_o !== CW'(q.size())) $display("FAIL model_count: got %0d expected %0d", count_o, q.size());
        else passed++;
        checks++;
        if (instr_valid_o !== (q.size() != 0)) $display("FAIL model_valid: got %b expected %b", instr_valid_o, q.size() != 0);
        else passed++;
        if (q.size() != 0) begin
            head = q[0];
            checks++;
            if (pc_o !== head.pc || instr_o !== head.instr)
                $display("FAIL model_head: got pc=%h instr=%h expected pc=%h instr=%h", pc_o, instr_o, head.pc, head.instr);
            else passed++;
        end
        if (imem_req_o === 1'b1) begin
            checks++;
            if (imem_addr_o !== (stale ? stale_addr : exp_addr))
                $display("FAIL model_req_addr: got %h expected %h", imem_addr_o, stale ? stale_addr : exp_addr);
            else passed++;
        end

        ack_eff       = ack && (imem_req_o === 1'b1);
        imem_ack_i    = ack_eff;
        imem_data_i   = data;
        instr_ready_i = rdy;
        redirect_i    = redir;
        redirect_pc_i = rpc;

        do_pop = (q.size() != 0) && rdy && !redir;
        if (redir) begin
            q.delete();
            if (imem_req_o === 1'b1) begin
                if (ack_eff) stale = 1'b0;
                else if (!stale) begin
                    stale      = 1'b1;
                    stale_addr = exp_addr;
                end
            end
            exp_addr = rpc;
        end else begin
            if (do_pop) void'(q.pop_front());
            if (ack_eff) begin
                if (stale) stale = 1'b0;
                else begin
                    checks++;
                    if (q.size() >= DEPTH) $display("FAIL model_overflow: push with %0d entries after pop", q.size());
                    else passed++;
                    q.push_back('{pc: exp_addr, instr: data});
                    exp_addr = exp_addr + 32'd4;
                    pushes++;
                end
            end
        end
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        imem_ack_i = 1'b0; imem_data_i = '0; redirect_i = 1'b0;
        redirect_pc_i = '0; instr_ready_i = 1'b0;
        #12;
        checks++; if (imem_req_o !== 1'b0) $display("FAIL reset_req: got %b expected 0", imem_req_o); else passed++;
        checks++; if (imem_addr_o !== RESET_PC) $display("FAIL reset_addr: got %h expected %h", imem_addr_o, RESET_PC); else passed++;
        checks++; if (instr_valid_o !== 1'b0) $display("FAIL reset_valid: got %b expected 0", instr_valid_o); else passed++;
        checks++; if (instr_o !== 32'd0) $display("FAIL reset_instr: got %h expected 0", instr_o); else passed++;
        checks++; if (pc_o !== 32'd0) $display("FAIL reset_pc: got %h expected 0", pc_o); else passed++;
        checks++; if (count_o !== '0) $display("FAIL reset_count: got %0d expected 0", count_o); else passed++;
        @(negedge clk_i);
        rst_i = 1'b0;
        model_clear();
    endtask

    task automatic test_stream();
        step(1'b1, 32'hA000_0000, 1'b1, 1'b0, '0);
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC)
            $display("FAIL stream_first_req: got req=%b addr=%h expected req=1 addr=%h", imem_req_o, imem_addr_o, RESET_PC);
        else passed++;
        for (int n = 2; n <= 12; n++) begin
            step(1'b1, 32'hA000_0000 + 32'(n), 1'b1, 1'b0, '0);
            checks++;
            if (instr_valid_o !== 1'b1 || pc_o !== 32'(4 * (n - 2)) || count_o !== CW'(1))
                $display("FAIL stream_rate: got valid=%b pc=%h count=%0d expected valid=1 pc=%h count=1",
                         instr_valid_o, pc_o, count_o, 32'(4 * (n - 2)));
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int n = 0; n < 8; n++) step(1'b1, $urandom, 1'b0, 1'b0, '0);
        checks++;
        if (count_o !== CW'(DEPTH) || imem_req_o !== 1'b0)
            $display("FAIL full_stop: got count=%0d req=%b expected count=4 req=0", count_o, imem_req_o);
        else passed++;
        step(1'b0, '0, 1'b1, 1'b0, '0);
        checks++;
        if (count_o !== CW'(3) || imem_req_o !== 1'b0)
            $display("FAIL full_pop: got count=%0d req=%b expected count=3 req=0", count_o, imem_req_o);
        else passed++;
        step(1'b0, '0, 1'b0, 1'b0, '0);
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'd16)
            $display("FAIL full_refetch: got req=%b addr=%h expected req=1 addr=00000010", imem_req_o, imem_addr_o);
        else passed++;
    endtask

    task automatic test_redirect_wait();
        step(1'b0, '0, 1'b0, 1'b1, 32'h100);
        checks++;
        if (count_o !== '0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'd16)
            $display("FAIL drop_enter: got count=%0d req=%b addr=%h expected count=0 req=1 addr=00000010",
                     count_o, imem_req_o, imem_addr_o);
        else passed++;
        step(1'b0, '0, 1'b0, 1'b0, '0);
        step(1'b1, 32'h0000_DEAD, 1'b1, 1'b0, '0);
        checks++;
        if (count_o !== '0 || instr_valid_o !== 1'b0 || imem_req_o !== 1'b0)
            $display("FAIL drop_discard: got count=%0d valid=%b req=%b expected 0/0/0", count_o, instr_valid_o, imem_req_o);
        else passed++;
        step(1'b0, '0, 1'b0, 1'b0, '0);
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100)
            $display("FAIL drop_refetch: got req=%b addr=%h expected req=1 addr=00000100", imem_req_o, imem_addr_o);
        else passed++;
    endtask

    task automatic test_redirect_ack();
        step(1'b1, 32'h1111_2222, 1'b1, 1'b1, 32'h200);
        checks++;
        if (count_o !== '0 || imem_req_o !== 1'b0)
            $display("FAIL redir_ack_nopush: got count=%0d req=%b expected count=0 req=0", count_o, imem_req_o);
        else passed++;
        step(1'b0, '0, 1'b0, 1'b0, '0);
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200)
            $display("FAIL redir_ack_refetch: got req=%b addr=%h expected req=1 addr=00000200", imem_req_o, imem_addr_o);
        else passed++;
    endtask

    task automatic test_wrap();
        step(1'b0, '0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b1, 32'h0BAD_0BAD, 1'b0, 1'b0, '0);
        step(1'b0, '0, 1'b0, 1'b0, '0);
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hFFFF_FFFC)
            $display("FAIL wrap_req: got req=%b addr=%h expected req=1 addr=fffffffc", imem_req_o, imem_addr_o);
        else passed++;
        step(1'b1, 32'h0000_1234, 1'b0, 1'b0, '0);
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'd0 || pc_o !== 32'hFFFF_FFFC || instr_o !== 32'h1234)
            $display("FAIL wrap_next: got req=%b addr=%h pc=%h instr=%h expected req=1 addr=0 pc=fffffffc instr=1234",
                     imem_req_o, imem_addr_o, pc_o, instr_o);
        else passed++;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int n = 0; n < 4; n++) step(1'b1, 32'hC000_0000 + 32'(n), 1'b0, 1'b0, '0);
        checks++;
        if (count_o !== CW'(3) || imem_req_o !== 1'b1)
            $display("FAIL areset_setup: got count=%0d req=%b expected count=3 req=1", count_o, imem_req_o);
        else passed++;
        #2 rst_i = 1'b1;
        #1;
        checks++;
        if (imem_req_o !== 1'b0 || imem_addr_o !== RESET_PC || instr_valid_o !== 1'b0 ||
            instr_o !== 32'd0 || pc_o !== 32'd0 || count_o !== '0)
            $display("FAIL areset_immediate: got req=%b addr=%h valid=%b instr=%h pc=%h count=%0d expected all reset",
                     imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, count_o);
        else passed++;
        @(negedge clk_i);
        rst_i = 1'b0;
        model_clear();
        step(1'b0, '0, 1'b0, 1'b0, '0);
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC)
            $display("FAIL areset_refetch: got req=%b addr=%h expected req=1 addr=%h", imem_req_o, imem_addr_o, RESET_PC);
        else passed++;
    endtask

    task automatic test_random();
        int start_pushes;
        start_pushes = pushes;
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 19) == 0, $urandom & 32'hFFFF_FFFC);
        end
        checks++;
        if (pushes - start_pushes < 20)
            $display("FAIL random_progress: got %0d pushes expected at least 20", pushes - start_pushes);
        else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        pushes = 0;
        model_clear();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_ack();
        test_wrap();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
